// File: rtl/ddr_init_ref_sequencer.sv
// DDR4 command-bus owner. Runs the power-up / mode-register / ZQ calibration sequence,
// then passes scheduler commands to the pins and inserts periodic refreshes.
module ddr_init_ref_sequencer #(
  parameter int unsigned T_RST_L  = 20,
  parameter int unsigned T_CKE    = 50,
  parameter int unsigned T_IS     = 1,
  parameter int unsigned T_XPR    = 10,
  parameter int unsigned T_MRD    = 8,
  parameter int unsigned T_MOD    = 24,
  parameter int unsigned T_ZQ     = 512,
  parameter int unsigned T_REF    = 780,
  parameter int unsigned T_RFC    = 26,
  parameter int unsigned REF_WARN = 16,
  parameter logic [13:0] MR0_VAL  = 14'h0,
  parameter logic [13:0] MR1_VAL  = 14'h0,
  parameter logic [13:0] MR2_VAL  = 14'h0,
  parameter logic [13:0] MR3_VAL  = 14'h0,
  parameter logic [13:0] MR4_VAL  = 14'h0,
  parameter logic [13:0] MR5_VAL  = 14'h0,
  parameter logic [13:0] MR6_VAL  = 14'h0
) (
  input  logic        clock_t,
  input  logic        reset,
  input  logic        usr_valid,
  output logic        usr_ready,
  input  logic        usr_act_n,
  input  logic        usr_ras_n_a16,
  input  logic        usr_cas_n_a15,
  input  logic        usr_we_n_a14,
  input  logic [1:0]  usr_bg_addr,
  input  logic [1:0]  usr_ba_addr,
  input  logic [13:0] usr_addr,
  output logic        reset_n,
  output logic        cke,
  output logic        cs_n,
  output logic        act_n,
  output logic        ras_n_a16,
  output logic        cas_n_a15,
  output logic        we_n_a14,
  output logic [1:0]  bg_addr,
  output logic [1:0]  ba_addr,
  output logic [13:0] addr,
  output logic        init_done,
  output logic        ref_warn
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned STEP_W = 3;

  localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(6);
  localparam logic [CNT_W-1:0]  REF_LAST   = CNT_W'(T_REF - 1);
  localparam logic [CNT_W-1:0]  WARN_FIRST = CNT_W'(T_REF - REF_WARN);
  localparam logic [CNT_W-1:0]  RFC_LAST   = CNT_W'(T_RFC);

  typedef struct packed {
    logic              cs_n;
    logic              act_n;
    logic              ras_n;
    logic              cas_n;
    logic              we_n;
    logic [1:0]        bg;
    logic [1:0]        ba;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  localparam cmd_t DES_CMD = '{cs_n: 1'b1, act_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1,
                               we_n: 1'b1, bg: 2'b00, ba: 2'b00, addr: 14'h0000};
  localparam cmd_t REF_CMD = '{cs_n: 1'b0, act_n: 1'b1, ras_n: 1'b0, cas_n: 1'b0,
                               we_n: 1'b1, bg: 2'b00, ba: 2'b00, addr: 14'h0000};
  localparam cmd_t ZQCL_CMD = '{cs_n: 1'b0, act_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1,
                                we_n: 1'b0, bg: 2'b00, ba: 2'b00, addr: 14'h0400};

  typedef enum logic [2:0] {
    RST_LOW,
    CKE_WAIT,
    XPR_WAIT,
    MRS_SEQ,
    MOD_WAIT,
    ZQ_WAIT,
    RUN
  } state_t;

  // MRS for sequence step 0..6, issued in order MR3, MR6, MR5, MR4, MR2, MR1, MR0.
  function automatic cmd_t mrs_cmd(input logic [STEP_W-1:0] step);
    logic [2:0]        idx;
    logic [ADDR_W-1:0] val;
    case (step)
      3'd0:    idx = 3'd3;
      3'd1:    idx = 3'd6;
      3'd2:    idx = 3'd5;
      3'd3:    idx = 3'd4;
      3'd4:    idx = 3'd2;
      3'd5:    idx = 3'd1;
      default: idx = 3'd0;
    endcase
    case (idx)
      3'd0:    val = MR0_VAL;
      3'd1:    val = MR1_VAL;
      3'd2:    val = MR2_VAL;
      3'd3:    val = MR3_VAL;
      3'd4:    val = MR4_VAL;
      3'd5:    val = MR5_VAL;
      default: val = MR6_VAL;
    endcase
    mrs_cmd = '{cs_n: 1'b0, act_n: 1'b1, ras_n: 1'b0, cas_n: 1'b0, we_n: 1'b0,
                bg: {1'b0, idx[2]}, ba: idx[1:0], addr: val};
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  rt_q, rt_d;
  logic              refd_q, refd_d;
  logic              reset_n_q, reset_n_d;
  logic              cke_q, cke_d;
  logic              init_done_q, init_done_d;
  logic              usr_ready_q, usr_ready_d;
  logic              ref_warn_q, ref_warn_d;
  cmd_t              bus_q, bus_d;
  cmd_t              usr_cmd_c;

  assign usr_cmd_c = '{cs_n: 1'b0, act_n: usr_act_n, ras_n: usr_ras_n_a16,
                       cas_n: usr_cas_n_a15, we_n: usr_we_n_a14,
                       bg: usr_bg_addr, ba: usr_ba_addr, addr: usr_addr};

  always_ff @(posedge clock_t) begin
    if (reset) begin
      state_q     <= RST_LOW;
      cnt_q       <= CNT_W'(T_RST_L - 1);
      step_q      <= '0;
      rt_q        <= '0;
      refd_q      <= 1'b0;
      reset_n_q   <= 1'b0;
      cke_q       <= 1'b0;
      init_done_q <= 1'b0;
      usr_ready_q <= 1'b0;
      ref_warn_q  <= 1'b0;
      bus_q       <= DES_CMD;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      rt_q        <= rt_d;
      refd_q      <= refd_d;
      reset_n_q   <= reset_n_d;
      cke_q       <= cke_d;
      init_done_q <= init_done_d;
      usr_ready_q <= usr_ready_d;
      ref_warn_q  <= ref_warn_d;
      bus_q       <= bus_d;
    end
  end

  // Every output is computed for the next cycle, so each wait counts down to 0 and the
  // command is launched on the cycle the count expires.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    rt_d        = rt_q;
    refd_d      = refd_q;
    reset_n_d   = reset_n_q;
    cke_d       = cke_q;
    init_done_d = init_done_q;
    usr_ready_d = 1'b0;
    ref_warn_d  = 1'b0;
    bus_d       = DES_CMD;

    case (state_q)
      RST_LOW: begin
        if (cnt_q == '0) begin
          state_d   = CKE_WAIT;
          cnt_d     = CNT_W'(T_CKE - 1);
          reset_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CKE_WAIT: begin
        if (cnt_q == '0) begin
          state_d = XPR_WAIT;
          cnt_d   = CNT_W'(T_IS + T_XPR - 1);
          cke_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      XPR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = MRS_SEQ;
          bus_d   = mrs_cmd('0);
          step_d  = STEP_W'(1);
          cnt_d   = CNT_W'(T_MRD - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MRS_SEQ: begin
        if (cnt_q == '0) begin
          bus_d = mrs_cmd(step_q);
          if (step_q == LAST_STEP) begin
            state_d = MOD_WAIT;
            cnt_d   = CNT_W'(T_MOD - 1);
          end else begin
            step_d = step_q + STEP_W'(1);
            cnt_d  = CNT_W'(T_MRD - 1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      MOD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ZQ_WAIT;
          bus_d   = ZQCL_CMD;
          cnt_d   = CNT_W'(T_ZQ);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ZQ_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RUN;
          init_done_d = 1'b1;
          usr_ready_d = 1'b1;
          rt_d        = '0;
          refd_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RUN: begin
        // usr_ready is already low on the due cycle, so REF never collides with an accept.
        if (rt_q == REF_LAST) begin
          rt_d   = '0;
          refd_d = 1'b1;
          bus_d  = REF_CMD;
        end else begin
          rt_d = rt_q + CNT_W'(1);
          if (usr_valid && usr_ready_q) begin
            bus_d = usr_cmd_c;
          end
        end
        ref_warn_d  = (rt_d >= WARN_FIRST);
        usr_ready_d = !((rt_d == REF_LAST) || (refd_d && (rt_d <= RFC_LAST)));
      end
      default: begin
        state_d = RST_LOW;
        cnt_d   = CNT_W'(T_RST_L - 1);
      end
    endcase
  end

  assign reset_n   = reset_n_q;
  assign cke       = cke_q;
  assign init_done = init_done_q;
  assign usr_ready = usr_ready_q;
  assign ref_warn  = ref_warn_q;
  assign cs_n      = bus_q.cs_n;
  assign act_n     = bus_q.act_n;
  assign ras_n_a16 = bus_q.ras_n;
  assign cas_n_a15 = bus_q.cas_n;
  assign we_n_a14  = bus_q.we_n;
  assign bg_addr   = bus_q.bg;
  assign ba_addr   = bus_q.ba;
  assign addr      = bus_q.addr;

endmodule
